// File: rtl/majority_sched_pkg.sv
// majority_sched_pkg: state encoding (sched_state_t) and default sizing (NUM_REQ_DEF, VOTE_W_DEF) for the majority vote scheduler
package majority_sched_pkg;
  typedef enum logic [1:0] {IDLE, EVAL, RESP} sched_state_t;
  localparam int NUM_REQ_DEF = 4;
  localparam int VOTE_W_DEF = 4;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; req/ptr in, one-hot gnt and encoded idx out (lowest offset from ptr wins)
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx
);
  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    j = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (req[j]) begin
        gnt = NUM_REQ'(1) << j;
        idx = ID_W'(j);
      end
    end
  end
endmodule

// File: rtl/majority_vote_scheduler.sv
// majority_vote_scheduler: round-robin time-share of one external majority voter; req/vote_data in, gnt out, mv_in/mv_enb/mv_y to voter, res_valid/res_ready/res_id/res_y/res_tie result handshake
module majority_vote_scheduler
  import majority_sched_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int VOTE_W = VOTE_W_DEF,
  parameter int ID_W = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*VOTE_W-1:0] vote_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [VOTE_W-1:0]         mv_in,
  output logic                      mv_enb,
  input  logic                      mv_y,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [ID_W-1:0]           res_id,
  output logic                      res_y,
  output logic                      res_tie
);
  sched_state_t st, nxt;
  logic [ID_W-1:0] ptr, id_q, arb_idx;
  logic [VOTE_W-1:0] data_q;
  logic [NUM_REQ-1:0] arb_gnt;
  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req(req),
    .ptr(ptr),
    .gnt(arb_gnt),
    .idx(arb_idx)
  );
  always_comb begin
    nxt = st == IDLE ? (|req ? EVAL : IDLE) : st == EVAL ? RESP : (res_ready ? IDLE : RESP);
    gnt = (st == IDLE && !rst) ? arb_gnt : '0;
    mv_enb = st == EVAL;
    mv_in = st == EVAL ? data_q : '0;
    res_valid = st == RESP;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      ptr <= '0;
      id_q <= '0;
      data_q <= '0;
      res_id <= '0;
      res_y <= 1'b0;
      res_tie <= 1'b0;
    end else begin
      st <= nxt;
      if (st == IDLE && |req) begin
        data_q <= vote_data[arb_idx*VOTE_W +: VOTE_W];
        id_q <= arb_idx;
        ptr <= int'(arb_idx) == NUM_REQ - 1 ? '0 : arb_idx + 1'b1;
      end
      if (st == EVAL) begin
        res_y <= mv_y;
        res_id <= id_q;
        res_tie <= $countones(data_q) == VOTE_W / 2;
      end
    end
  end
endmodule

// File: tb/tb_majority_vote_scheduler.sv
// tb_majority_vote_scheduler: directed self-checking bench with a behavioural 4-input majority voter on the mv_* port
module tb_majority_vote_scheduler;
  logic clk = 1'b0, rst = 1'b1, res_ready = 1'b1;
  logic mv_enb, mv_y, res_valid, res_y, res_tie;
  logic [3:0] req = '0, gnt, mv_in;
  logic [15:0] vote_data = '0;
  logic [1:0] res_id;
  int n_cmp = 0, n_bad = 0;
  logic [15:0] exp_maj = 16'b1110_1000_1000_0000;
  logic [15:0] exp_tie = 16'b0001_0110_0110_1000;
  always #5 clk = ~clk;
  assign mv_y = mv_enb & ($countones(mv_in) > 2);
  majority_vote_scheduler dut (
    .clk(clk), .rst(rst), .req(req), .vote_data(vote_data), .gnt(gnt),
    .mv_in(mv_in), .mv_enb(mv_enb), .mv_y(mv_y), .res_valid(res_valid),
    .res_ready(res_ready), .res_id(res_id), .res_y(res_y), .res_tie(res_tie)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    req = 4'b1111;
    tick;
    tick;
    #1;
    n_cmp++;
    if ({gnt, mv_enb, mv_in, res_valid, res_id, res_y, res_tie} !== 14'b0) begin
      n_bad++;
      $display("FAIL reset: got %b required 0", {gnt, mv_enb, mv_in, res_valid, res_id, res_y, res_tie});
    end
    rst = 1'b0;
    req = '0;
    tick;
  endtask
  task automatic test_single;
    req = 4'b0001;
    vote_data = 16'h000D;
    #1;
    n_cmp++;
    if ({gnt, mv_enb, mv_in, res_valid} !== {4'b0001, 1'b0, 4'b0000, 1'b0}) begin
      n_bad++;
      $display("FAIL single_grant: got %b required %b", {gnt, mv_enb, mv_in, res_valid}, {4'b0001, 1'b0, 4'b0000, 1'b0});
    end
    tick;
    req = '0;
    #1;
    n_cmp++;
    if ({gnt, mv_enb, mv_in, res_valid} !== {4'b0000, 1'b1, 4'b1101, 1'b0}) begin
      n_bad++;
      $display("FAIL single_eval: got %b required %b", {gnt, mv_enb, mv_in, res_valid}, {4'b0000, 1'b1, 4'b1101, 1'b0});
    end
    tick;
    #1;
    n_cmp++;
    if ({res_valid, res_id, res_y, res_tie, mv_enb, mv_in} !== {1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 4'b0}) begin
      n_bad++;
      $display("FAIL single_resp: got %b required %b", {res_valid, res_id, res_y, res_tie, mv_enb, mv_in}, {1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 4'b0});
    end
    tick;
    #1;
    n_cmp++;
    if ({res_valid, gnt} !== 5'b0) begin
      n_bad++;
      $display("FAIL single_done: got %b required 0", {res_valid, gnt});
    end
    tick;
  endtask
  task automatic test_tie;
    req = 4'b0100;
    vote_data = 16'h0600;
    #1;
    n_cmp++;
    if (gnt !== 4'b0100) begin
      n_bad++;
      $display("FAIL tie_grant: got %b required 0100", gnt);
    end
    tick;
    req = '0;
    #1;
    n_cmp++;
    if ({mv_enb, mv_in} !== 5'b1_0110) begin
      n_bad++;
      $display("FAIL tie_eval: got %b required 10110", {mv_enb, mv_in});
    end
    tick;
    #1;
    n_cmp++;
    if ({res_valid, res_id, res_y, res_tie} !== {1'b1, 2'd2, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL tie_resp: got %b required %b", {res_valid, res_id, res_y, res_tie}, {1'b1, 2'd2, 1'b0, 1'b1});
    end
    tick;
  endtask
  task automatic test_fairness;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    req = 4'b1111;
    vote_data = 16'h7E31;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_cmp++;
      if (gnt !== 4'(1 << (i % 4))) begin
        n_bad++;
        $display("FAIL fair_grant[%0d]: got %b required %b", i, gnt, 4'(1 << (i % 4)));
      end
      tick;
      #1;
      n_cmp++;
      if ({gnt, mv_enb} !== 5'b0000_1) begin
        n_bad++;
        $display("FAIL fair_eval[%0d]: got %b required 00001", i, {gnt, mv_enb});
      end
      tick;
      #1;
      n_cmp++;
      if ({gnt, res_valid, res_id} !== {4'b0, 1'b1, 2'(i % 4)}) begin
        n_bad++;
        $display("FAIL fair_resp[%0d]: got %b required %b", i, {gnt, res_valid, res_id}, {4'b0, 1'b1, 2'(i % 4)});
      end
      tick;
    end
    req = '0;
    tick;
  endtask
  task automatic test_backpressure;
    res_ready = 1'b0;
    req = 4'b0011;
    vote_data = 16'h000B;
    #1;
    n_cmp++;
    if (gnt !== 4'b0001) begin
      n_bad++;
      $display("FAIL bp_grant: got %b required 0001", gnt);
    end
    tick;
    req = 4'b0010;
    #1;
    n_cmp++;
    if ({gnt, mv_enb, mv_in} !== {4'b0, 1'b1, 4'b1011}) begin
      n_bad++;
      $display("FAIL bp_eval: got %b required %b", {gnt, mv_enb, mv_in}, {4'b0, 1'b1, 4'b1011});
    end
    tick;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++;
      if ({res_valid, res_id, res_y, res_tie, gnt, mv_enb} !== {1'b1, 2'd0, 1'b1, 1'b0, 4'b0, 1'b0}) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: got %b required %b", i, {res_valid, res_id, res_y, res_tie, gnt, mv_enb}, {1'b1, 2'd0, 1'b1, 1'b0, 4'b0, 1'b0});
      end
      tick;
    end
    res_ready = 1'b1;
    #1;
    n_cmp++;
    if ({res_valid, gnt} !== 5'b1_0000) begin
      n_bad++;
      $display("FAIL bp_release: got %b required 10000", {res_valid, gnt});
    end
    tick;
    #1;
    n_cmp++;
    if ({res_valid, gnt} !== 5'b0_0010) begin
      n_bad++;
      $display("FAIL bp_idle: got %b required 00010", {res_valid, gnt});
    end
    tick;
    req = '0;
    tick;
    tick;
  endtask
  task automatic test_reset_eval;
    req = 4'b0101;
    vote_data = 16'h0F00;
    #1;
    n_cmp++;
    if (gnt !== 4'b0100) begin
      n_bad++;
      $display("FAIL rst_pre_grant: got %b required 0100", gnt);
    end
    tick;
    req = '0;
    #1;
    n_cmp++;
    if (mv_enb !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_pre_eval: got %b required 1", mv_enb);
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({gnt, mv_enb, mv_in, res_valid, res_id, res_y, res_tie} !== 14'b0) begin
      n_bad++;
      $display("FAIL rst_eval_outputs: got %b required 0", {gnt, mv_enb, mv_in, res_valid, res_id, res_y, res_tie});
    end
    for (int i = 0; i < 4; i++) begin
      tick;
      #1;
      n_cmp++;
      if (res_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL rst_no_result[%0d]: got %b required 0", i, res_valid);
      end
    end
    req = 4'b1001;
    #1;
    n_cmp++;
    if (gnt !== 4'b0001) begin
      n_bad++;
      $display("FAIL rst_ptr_zero: got %b required 0001", gnt);
    end
    tick;
    req = '0;
    tick;
    tick;
  endtask
  task automatic test_enable;
    logic [3:0] wv;
    for (int w = 0; w < 16; w++) begin
      wv = 4'(w);
      vote_data = {wv, 12'h000};
      req = 4'b1000;
      #1;
      n_cmp++;
      if ({gnt, mv_enb, mv_in} !== {4'b1000, 1'b0, 4'b0}) begin
        n_bad++;
        $display("FAIL en_idle[%0d]: got %b required %b", w, {gnt, mv_enb, mv_in}, {4'b1000, 1'b0, 4'b0});
      end
      tick;
      req = '0;
      #1;
      n_cmp++;
      if ({mv_enb, mv_in} !== {1'b1, wv}) begin
        n_bad++;
        $display("FAIL en_eval[%0d]: got %b required %b", w, {mv_enb, mv_in}, {1'b1, wv});
      end
      tick;
      #1;
      n_cmp++;
      if ({res_valid, res_id, res_y, res_tie, mv_enb, mv_in} !== {1'b1, 2'd3, exp_maj[w], exp_tie[w], 1'b0, 4'b0}) begin
        n_bad++;
        $display("FAIL en_resp[%0d]: got %b required %b", w, {res_valid, res_id, res_y, res_tie, mv_enb, mv_in}, {1'b1, 2'd3, exp_maj[w], exp_tie[w], 1'b0, 4'b0});
      end
      n_cmp++;
      if (res_tie && res_y) begin
        n_bad++;
        $display("FAIL en_tie_strict[%0d]: got y=%b tie=%b required not both 1", w, res_y, res_tie);
      end
      tick;
    end
  endtask
  initial begin
    test_reset;
    test_single;
    test_tie;
    test_fairness;
    test_backpressure;
    test_reset_eval;
    test_enable;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/majority_vote_scheduler.md
Name: majority_vote_scheduler

Overview:
- Time-shares one combinational 4-input majority voter among NUM_REQ requesters.
- Arbitrates requests round-robin and latches the winner's vote word.
- Drives the voter's enable and input, samples its output, and returns the decision with the requester ID over a valid/ready handshake.
- Sits between requester channels and the single shared voter instance.

Parameters:
- NUM_REQ, 4, number of requester channels (2..8).
- VOTE_W, 4, vote word width; must match the shared voter input width.
- ID_W, $clog2(NUM_REQ), width of the requester ID.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester request; held high until granted.
- vote_data  input  NUM_REQ*VOTE_W  packed vote words; requester i uses slice [i*VOTE_W +: VOTE_W].
- gnt  output  NUM_REQ  one-hot, one-cycle acceptance pulse.
- mv_in  output  VOTE_W  vote word driven to the shared voter.
- mv_enb  output  1  shared voter enable.
- mv_y  input  1  shared voter result (combinational from mv_in/mv_enb).
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts result.
- res_id  output  ID_W  requester index of the result.
- res_y  output  1  majority decision (1 when ones > zeros).
- res_tie  output  1  ones == zeros in the latched word.

Behaviour:
- Single clock; reset is synchronous and active-high.
- Reset values: all outputs 0. State is IDLE. RR pointer is 0, so requester 0 has highest priority.
- FSM states: IDLE, EVAL, RESP.
- IDLE:
  - If req != 0, select the first set bit searching upward from the RR pointer, with wrap.
  - Pulse gnt[winner] for exactly this cycle.
  - Latch the winner's vote word into data_q and the winner index into id_q.
  - Set RR pointer to winner+1 mod NUM_REQ, then go to EVAL.
  - If req == 0, stay in IDLE with gnt = 0.
- EVAL:
  - mv_enb = 1 and mv_in = data_q for exactly one cycle.
  - At the clock edge, capture mv_y into res_y, id_q into res_id, and (popcount(data_q) == VOTE_W/2) into res_tie.
  - Go to RESP.
- RESP:
  - res_valid = 1, with res_y, res_id and res_tie held stable.
  - On res_valid && res_ready, drop res_valid next cycle and go to IDLE.
  - If res_ready stays low, hold indefinitely. No new grant is issued while in RESP.
- Outside EVAL, mv_enb = 0 and mv_in = 0.
- Latency: request seen in IDLE at cycle t gives gnt at t, res_valid at t+2. Minimum 3 cycles per transaction when res_ready is tied high.
- Requests arriving while busy are not granted and must persist.
- A requester dropping req before gnt is legal and loses its turn.
- Same-cycle requests: only one grant. Round-robin guarantees each active requester is granted within NUM_REQ transactions.
- res_tie = 1 implies res_y = 0 (strict majority). The block does not check this; the bench does.
- Reset mid-operation:
  - Any latched transaction is discarded with no result.
  - res_valid drops on the cycle after rst is sampled.
  - RR pointer returns to 0.
- ID wrap: the pointer after index NUM_REQ-1 is 0.

Decomposition:
- Package majority_sched_pkg:
  - typedef enum logic [1:0] {IDLE, EVAL, RESP} sched_state_t.
  - Default constants NUM_REQ_DEF = 4 and VOTE_W_DEF = 4.
- Sub-module rr_arbiter:
  - Inputs: req and pointer. Outputs: one-hot grant and encoded index.
  - Purely combinational, parameterised by NUM_REQ.
- The shared majority voter stays outside this block. The top level connects mv_in/mv_enb/mv_y.

Test Plan:
- Single request, ready tied high: req=0001, vote_data[3:0]=4'b1101 -> gnt=0001 at t, mv_enb=1 and mv_in=1101 at t+1, res_valid at t+2 with res_id=0, res_y=1, res_tie=0.
- Tie word: requester 2 votes 4'b0110 -> res_y=0, res_tie=1, res_id=2.
- Fairness: req=1111 held for 8 transactions -> grant order 0,1,2,3,0,1,2,3, each gnt a one-cycle pulse.
- Backpressure: res_ready low for 5 cycles in RESP -> res_valid and result fields stable for 5 cycles, no gnt issued, IDLE entered one cycle after ready rises.
- Reset in EVAL: assert rst during EVAL -> next cycle all outputs 0, no res_valid ever for that transaction, next grant goes to requester 0 if it is requesting.
- Enable gating: in every non-EVAL cycle mv_enb=0 and mv_in=0. In EVAL, the captured res_y equals the reference majority of data_q for all 16 vote words.
